// File: rtl/memory_unit.sv
// Word-addressed main memory with a wait-state access controller for the Mini SRC MDR.
// A request is latched in IDLE, then WAIT counts down, then DONE pulses mfc for one cycle.
module memory_unit #(
    parameter int    ADDR_WIDTH  = 9,
    parameter int    DATA_WIDTH  = 32,
    parameter int    WAIT_STATES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  read_req,
    input  logic                  write_req,
    input  logic [ADDR_WIDTH-1:0] mar_addr,
    input  logic [DATA_WIDTH-1:0] mdr_out,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  mfc,
    output logic                  busy,
    output logic                  req_err
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    is_write_q, is_write_d;
    logic                    req_err_q, req_err_d;
    logic [DATA_WIDTH-1:0]   mdatain_q;
    logic                    do_access;

    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        req_err_d  = 1'b0;
        do_access  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (read_req ^ write_req) begin
                    addr_d     = mar_addr;
                    wdata_d    = mdr_out;
                    is_write_d = write_req;
                    cnt_d      = WAIT_INIT;
                    state_d    = ST_WAIT;
                end else if (read_req && write_req) begin
                    req_err_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    do_access = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            req_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            req_err_q  <= req_err_d;
        end
    end

    // NOTE: the array has no reset so it maps onto RAM; clear only blocks an in-flight write.
    always_ff @(posedge clock) begin
        if (clear && do_access && is_write_q) mem[addr_q] <= wdata_q;
    end

    always_ff @(posedge clock) begin
        if (!clear)                        mdatain_q <= '0;
        else if (do_access && !is_write_q) mdatain_q <= mem[addr_q];
    end

    assign Mdatain = mdatain_q;
    assign mfc     = (state_q == ST_DONE);
    assign busy    = (state_q != ST_IDLE);
    assign req_err = req_err_q;

endmodule
